port_latency_ctrl: RTL and testbench
====================================

# port_latency_ctrl

Single-port latency controller that sits directly upstream of the dual-port memory; one instance drives each memory port. It delays each write request (enable, write-enable, address, data) by a programmable number of cycles before presenting it to the memory. Read requests go to the memory undelayed, and returned read data is re-timed to a programmable read latency with a valid flag. The block also reports in-flight writes and flags read-after-write hazards against them.

## Interface
- DATA_WIDTH, 8, width of data words
- ADDR_WIDTH, 4, width of address
- WR_LATENCY, 1, write delay in cycles; legal range ≥1
- RD_LATENCY, 1, request-to-data read latency in cycles; legal range ≥1
- PCNT_WIDTH, $clog2(WR_LATENCY+1), width of pending-write count

Ports:
- clk  in  1  sole clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- i_en  in  1  request strobe from the user side
- i_we  in  1  1 = write request, 0 = read request (qualified by i_en)
- i_addr  in  ADDR_WIDTH  request address
- i_din  in  DATA_WIDTH  write data
- i_mem_dout  in  DATA_WIDTH  registered read data from the memory port
- o_en_wr  out  1  delayed write enable to memory
- o_we  out  1  delayed write strobe to memory; identical to o_en_wr
- o_addr_wr  out  ADDR_WIDTH  delayed write address
- o_din  out  DATA_WIDTH  delayed write data
- o_en_rd  out  1  read enable to memory; combinational, equals i_en
- o_rd  out  1  read inhibit to memory; combinational, equals i_we
- o_addr_rd  out  ADDR_WIDTH  read address to memory; combinational, equals i_addr
- o_dout  out  DATA_WIDTH  re-timed read data
- o_dout_valid  out  1  o_dout holds data for a completed read
- o_wr_pending  out  PCNT_WIDTH  number of valid write stages in flight
- o_raw_hazard  out  1  current read hits an in-flight write address

## Operation
- Write pipe: WR_LATENCY stages, each holding {v, addr, data}.
  - Stage 1 loads v = i_en & i_we, plus i_addr and i_din, every clock.
  - Stage k loads from stage k-1 every clock, with no stall.
  - o_en_wr and o_we equal v of the last stage; o_addr_wr and o_din come from the last stage.
  - Address and data registers load unconditionally; they are don't-care when v = 0.
- Read path: o_en_rd, o_rd and o_addr_rd pass i_en, i_we and i_addr straight through. The memory returns data one edge later.
- Read-return pipe:
  - Valid stage r0 captures i_en & ~i_we each clock.
  - RD_LATENCY-1 further stages of {valid, data}; the first data stage captures i_mem_dout with r0.
  - RD_LATENCY = 1: o_dout = i_mem_dout and o_dout_valid = r0.
- o_wr_pending: combinational popcount of the write-stage v bits, range 0..WR_LATENCY.
- o_raw_hazard: combinational.
  - Equals i_en & ~i_we & (OR over all stages of v & addr == i_addr).
  - Includes the last stage: the memory reads before it writes on the same edge, so the read returns old data.
  - Hazard is informational only; the read still proceeds.
- Reset (asynchronous, any cycle):
  - All v bits, read valids and data/address registers clear to 0.
  - In-flight writes are dropped and never reach memory.
  - Reset values: o_en_wr = o_we = 0, o_addr_wr = o_din = 0, o_dout = 0, o_dout_valid = 0, o_wr_pending = 0, o_raw_hazard = 0.
  - Combinational pass-through outputs follow their inputs during reset.

## Timing
- A write presented in cycle t (sampled at edge t) appears on o_en_wr, o_addr_wr and o_din in cycle t+WR_LATENCY. The memory commits it at the end of that cycle.
- A read presented in cycle t gives o_dout_valid = 1 and correct o_dout in cycle t+RD_LATENCY. The valid pulse lasts one cycle per request.
- Back-to-back requests are accepted every cycle; throughput is 1/clk on both paths.
- Bubbles (i_en = 0) propagate as v = 0 stages.
- Reset deassertion: the first request is sampled at the first posedge with rst = 0.

## Test plan
- Reset: assert rst mid-burst with 2 writes in flight (WR_LATENCY = 3).
  - Outputs go to 0 immediately and o_wr_pending = 0.
  - No o_en_wr pulse follows.
- Write latency: WR_LATENCY = 3; write addr 5, data 0xA5 in cycle 10.
  - o_en_wr = 1, o_addr_wr = 5, o_din = 0xA5 in cycle 13 only.
  - o_wr_pending = 1 during cycles 11–13.
- Read latency: RD_LATENCY = 3 with the memory model preloaded mem[7] = 0x3C; read addr 7 in cycle 20.
  - o_dout_valid = 1 and o_dout = 0x3C in cycle 23 only.
- Streaming: 8 consecutive writes (addr 0–7, data = addr + 0x10), then 8 reads.
  - Memory contents match.
  - o_dout_valid is high for exactly 8 contiguous cycles with data 0x10–0x17.
- Hazard: WR_LATENCY = 2; write addr 9 in cycle 0, read addr 9 in cycle 1 → o_raw_hazard = 1 in cycle 1.
  - Read addr 9 in cycle 3 → o_raw_hazard = 0.
  - Read addr 4 in cycle 1 → o_raw_hazard = 0.
- Bubbles: pattern write, idle, write, idle with WR_LATENCY = 2.
  - o_en_wr toggles 1, 0, 1, 0 starting 2 cycles later.
  - o_wr_pending never exceeds 1.

Source files
------------

// File: rtl/port_latency_ctrl_if.sv
// Request/response bundle between the user side, port_latency_ctrl and one memory port.
// The master modport is the user and memory side; the slave modport is the controller.
interface port_latency_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned PCNT_WIDTH = 1
);
    logic                  i_en;
    logic                  i_we;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_din;
    logic [DATA_WIDTH-1:0] i_mem_dout;
    logic                  o_en_wr;
    logic                  o_we;
    logic [ADDR_WIDTH-1:0] o_addr_wr;
    logic [DATA_WIDTH-1:0] o_din;
    logic                  o_en_rd;
    logic                  o_rd;
    logic [ADDR_WIDTH-1:0] o_addr_rd;
    logic [DATA_WIDTH-1:0] o_dout;
    logic                  o_dout_valid;
    logic [PCNT_WIDTH-1:0] o_wr_pending;
    logic                  o_raw_hazard;

    modport master (
        output i_en, i_we, i_addr, i_din, i_mem_dout,
        input  o_en_wr, o_we, o_addr_wr, o_din, o_en_rd, o_rd, o_addr_rd,
        input  o_dout, o_dout_valid, o_wr_pending, o_raw_hazard
    );

    modport slave (
        input  i_en, i_we, i_addr, i_din, i_mem_dout,
        output o_en_wr, o_we, o_addr_wr, o_din, o_en_rd, o_rd, o_addr_rd,
        output o_dout, o_dout_valid, o_wr_pending, o_raw_hazard
    );
endinterface

// File: rtl/port_latency_ctrl.sv
// Per-port latency controller: delays writes by WR_LATENCY cycles, re-times read data to
// RD_LATENCY cycles, and reports in-flight writes plus read-after-write hazards.
module port_latency_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned WR_LATENCY = 1,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned PCNT_WIDTH = $clog2(WR_LATENCY + 1)
) (
    input  logic              clk,
    input  logic              rst,
    port_latency_ctrl_if.slave bus
);
    logic                  wr_v_q    [WR_LATENCY];
    logic [ADDR_WIDTH-1:0] wr_addr_q [WR_LATENCY];
    logic [DATA_WIDTH-1:0] wr_data_q [WR_LATENCY];
    logic                  rd0_q;
    logic [PCNT_WIDTH-1:0] pend_cnt;
    logic                  addr_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(WR_LATENCY); k++) begin
                wr_v_q[k]    <= 1'b0;
                wr_addr_q[k] <= '0;
                wr_data_q[k] <= '0;
            end
            rd0_q <= 1'b0;
        end else begin
            wr_v_q[0]    <= bus.i_en & bus.i_we;
            wr_addr_q[0] <= bus.i_addr;
            wr_data_q[0] <= bus.i_din;
            for (int k = 1; k < int'(WR_LATENCY); k++) begin
                wr_v_q[k]    <= wr_v_q[k-1];
                wr_addr_q[k] <= wr_addr_q[k-1];
                wr_data_q[k] <= wr_data_q[k-1];
            end
            rd0_q <= bus.i_en & ~bus.i_we;
        end
    end

    // The last stage counts as a hazard too: memory reads before it writes on the same edge.
    always_comb begin
        pend_cnt = '0;
        addr_hit = 1'b0;
        for (int k = 0; k < int'(WR_LATENCY); k++) begin
            pend_cnt = pend_cnt + PCNT_WIDTH'(wr_v_q[k]);
            addr_hit = addr_hit | (wr_v_q[k] & (wr_addr_q[k] == bus.i_addr));
        end
    end

    assign bus.o_en_wr      = wr_v_q[WR_LATENCY-1];
    assign bus.o_we         = wr_v_q[WR_LATENCY-1];
    assign bus.o_addr_wr    = wr_addr_q[WR_LATENCY-1];
    assign bus.o_din        = wr_data_q[WR_LATENCY-1];
    assign bus.o_en_rd      = bus.i_en;
    assign bus.o_rd         = bus.i_we;
    assign bus.o_addr_rd    = bus.i_addr;
    assign bus.o_wr_pending = pend_cnt;
    assign bus.o_raw_hazard = bus.i_en & ~bus.i_we & addr_hit;

    if (RD_LATENCY == 1) begin : g_rd_direct
        assign bus.o_dout       = bus.i_mem_dout;
        assign bus.o_dout_valid = rd0_q;
    end else begin : g_rd_pipe
        localparam int unsigned RdStages = RD_LATENCY - 1;

        logic                  rd_v_q [RdStages];
        logic [DATA_WIDTH-1:0] rd_d_q [RdStages];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < int'(RdStages); k++) begin
                    rd_v_q[k] <= 1'b0;
                    rd_d_q[k] <= '0;
                end
            end else begin
                rd_v_q[0] <= rd0_q;
                rd_d_q[0] <= bus.i_mem_dout;
                for (int k = 1; k < int'(RdStages); k++) begin
                    rd_v_q[k] <= rd_v_q[k-1];
                    rd_d_q[k] <= rd_d_q[k-1];
                end
            end
        end

        assign bus.o_dout       = rd_d_q[RdStages-1];
        assign bus.o_dout_valid = rd_v_q[RdStages-1];
    end
endmodule

// File: tb/tb_port_latency_ctrl.sv
// Directed bench for port_latency_ctrl: one instance with WR/RD latency 3, one with
// WR latency 2 / RD latency 1, each backed by a simple registered-read memory model.
module tb_port_latency_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst3, rst2;
    logic       ld_en;
    logic [3:0] ld_addr;
    logic [7:0] ld_data;
    logic [7:0] mem3 [16];
    logic [7:0] mem2 [16];

    int n_tests = 0;
    int n_fail  = 0;

    port_latency_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .PCNT_WIDTH(2)) bus3 ();
    port_latency_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .PCNT_WIDTH(2)) bus2 ();

    port_latency_ctrl #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .WR_LATENCY(3), .RD_LATENCY(3), .PCNT_WIDTH(2)
    ) dut3 (
        .clk(clk), .rst(rst3), .bus(bus3)
    );

    port_latency_ctrl #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .WR_LATENCY(2), .RD_LATENCY(1), .PCNT_WIDTH(2)
    ) dut2 (
        .clk(clk), .rst(rst2), .bus(bus2)
    );

    // Memory: registered read, old data returned when read and write hit the same edge.
    always @(posedge clk) begin
        if (bus3.o_en_rd && !bus3.o_rd) bus3.i_mem_dout <= mem3[bus3.o_addr_rd];
        if (bus3.o_en_wr) mem3[bus3.o_addr_wr] <= bus3.o_din;
        else if (ld_en) mem3[ld_addr] <= ld_data;
    end

    always @(posedge clk) begin
        if (bus2.o_en_rd && !bus2.o_rd) bus2.i_mem_dout <= mem2[bus2.o_addr_rd];
        if (bus2.o_en_wr) mem2[bus2.o_addr_wr] <= bus2.o_din;
    end

    typedef struct {
        logic       en;
        logic       we;
        logic [3:0] addr;
        logic [7:0] din;
        logic       x_en_wr;
        logic [3:0] x_addr;
        logic [7:0] x_din;
        logic [1:0] x_pend;
        logic       x_haz;
        logic       x_dv;
        logic [7:0] x_dout;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv3(input logic en, input logic we, input logic [3:0] a, input logic [7:0] d);
        bus3.i_en = en; bus3.i_we = we; bus3.i_addr = a; bus3.i_din = d;
    endtask

    task automatic drv2(input logic en, input logic we, input logic [3:0] a, input logic [7:0] d);
        bus2.i_en = en; bus2.i_we = we; bus2.i_addr = a; bus2.i_din = d;
    endtask

    initial begin
        int   n_valid;
        int   first_valid;
        int   last_valid;
        logic [1:0] exp_pend_b [7];
        logic       exp_en_b   [7];

        // Write 5/A5, read 5 (hazard, old data 55), read 7 (3C), later read 5 (new A5).
        tbl[0]  = '{1'b1, 1'b1, 4'd5, 8'hA5, 1'b0, 4'd0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 4'd5, 8'h00, 1'b0, 4'd0, 8'h00, 2'd1, 1'b1, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 1'b0, 4'd7, 8'h00, 1'b0, 4'd0, 8'h00, 2'd1, 1'b0, 1'b0, 8'h00};
        tbl[3]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 8'hA5, 2'd1, 1'b0, 1'b0, 8'h00};
        tbl[4]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 2'd0, 1'b0, 1'b1, 8'h55};
        tbl[5]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 2'd0, 1'b0, 1'b1, 8'h3C};
        tbl[6]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00};
        tbl[7]  = '{1'b1, 1'b0, 4'd5, 8'h00, 1'b0, 4'd0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00};
        tbl[8]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00};
        tbl[9]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00};
        tbl[10] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 2'd0, 1'b0, 1'b1, 8'hA5};
        tbl[11] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00};

        rst3 = 1'b1; rst2 = 1'b1;
        drv3(1'b0, 1'b0, 4'd0, 8'h00);
        drv2(1'b0, 1'b0, 4'd0, 8'h00);
        ld_en = 1'b1; ld_addr = 4'd5; ld_data = 8'h55;
        tick();
        ld_addr = 4'd7; ld_data = 8'h3C;
        tick();
        ld_en = 1'b0;

        chk("reset en_wr", bus3.o_en_wr, 0);
        chk("reset we", bus3.o_we, 0);
        chk("reset addr_wr", bus3.o_addr_wr, 0);
        chk("reset din", bus3.o_din, 0);
        chk("reset dout", bus3.o_dout, 0);
        chk("reset dout_valid", bus3.o_dout_valid, 0);
        chk("reset pending", bus3.o_wr_pending, 0);
        chk("reset hazard", bus3.o_raw_hazard, 0);
        chk("reset2 pending", bus2.o_wr_pending, 0);
        chk("reset2 dout_valid", bus2.o_dout_valid, 0);
        rst3 = 1'b0; rst2 = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drv3(tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].din);
            #1;
            chk($sformatf("row%0d en_wr", i), bus3.o_en_wr, tbl[i].x_en_wr);
            chk($sformatf("row%0d we", i), bus3.o_we, tbl[i].x_en_wr);
            if (tbl[i].x_en_wr) begin
                chk($sformatf("row%0d addr_wr", i), bus3.o_addr_wr, tbl[i].x_addr);
                chk($sformatf("row%0d din", i), bus3.o_din, tbl[i].x_din);
            end
            chk($sformatf("row%0d pending", i), bus3.o_wr_pending, tbl[i].x_pend);
            chk($sformatf("row%0d hazard", i), bus3.o_raw_hazard, tbl[i].x_haz);
            chk($sformatf("row%0d dout_valid", i), bus3.o_dout_valid, tbl[i].x_dv);
            if (tbl[i].x_dv) chk($sformatf("row%0d dout", i), bus3.o_dout, tbl[i].x_dout);
            chk($sformatf("row%0d en_rd", i), bus3.o_en_rd, tbl[i].en);
            chk($sformatf("row%0d rd", i), bus3.o_rd, tbl[i].we);
            chk($sformatf("row%0d addr_rd", i), bus3.o_addr_rd, tbl[i].addr);
            tick();
        end

        // Reset mid-burst with two writes in flight; they must never reach memory.
        drv3(1'b1, 1'b1, 4'd1, 8'h11);
        tick();
        drv3(1'b1, 1'b1, 4'd2, 8'h22);
        tick();
        drv3(1'b1, 1'b0, 4'd3, 8'h00);
        #1;
        chk("burst pending", bus3.o_wr_pending, 2);
        rst3 = 1'b1;
        #1;
        chk("midrst en_wr", bus3.o_en_wr, 0);
        chk("midrst addr_wr", bus3.o_addr_wr, 0);
        chk("midrst din", bus3.o_din, 0);
        chk("midrst pending", bus3.o_wr_pending, 0);
        chk("midrst dout_valid", bus3.o_dout_valid, 0);
        chk("midrst en_rd passthru", bus3.o_en_rd, 1);
        chk("midrst addr_rd passthru", bus3.o_addr_rd, 3);
        tick();
        drv3(1'b0, 1'b0, 4'd0, 8'h00);
        rst3 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("postrst c%0d en_wr", c), bus3.o_en_wr, 0);
            tick();
        end

        // Streaming: 8 writes then 8 reads back-to-back.
        n_valid = 0; first_valid = -1; last_valid = -1;
        for (int c = 0; c < 30; c++) begin
            if (c < 8) drv3(1'b1, 1'b1, 4'(c), 8'(c + 16));
            else if (c < 16) drv3(1'b1, 1'b0, 4'(c - 8), 8'h00);
            else drv3(1'b0, 1'b0, 4'd0, 8'h00);
            #1;
            if (bus3.o_dout_valid === 1'b1) begin
                if (first_valid < 0) first_valid = c;
                last_valid = c;
                chk($sformatf("stream dout%0d", n_valid), bus3.o_dout, 8'(n_valid + 16));
                n_valid++;
            end
            tick();
        end
        chk("stream valid count", n_valid, 8);
        chk("stream first valid cycle", first_valid, 11);
        chk("stream contiguous", last_valid - first_valid, 7);
        for (int a = 0; a < 8; a++) chk($sformatf("stream mem%0d", a), mem3[a], 8'(a + 16));

        // Hazard on WR_LATENCY=2: read right after the write, then after it retires.
        drv2(1'b1, 1'b1, 4'd9, 8'h99);
        tick();
        drv2(1'b1, 1'b0, 4'd9, 8'h00);
        #1;
        chk("haz read9 c1", bus2.o_raw_hazard, 1);
        tick();
        drv2(1'b0, 1'b0, 4'd0, 8'h00);
        #1;
        chk("rd1 dout_valid", bus2.o_dout_valid, 1);
        tick();
        drv2(1'b1, 1'b0, 4'd9, 8'h00);
        #1;
        chk("haz read9 c3", bus2.o_raw_hazard, 0);
        tick();
        drv2(1'b0, 1'b0, 4'd0, 8'h00);
        tick();

        drv2(1'b1, 1'b1, 4'd9, 8'h9A);
        tick();
        drv2(1'b1, 1'b0, 4'd4, 8'h00);
        #1;
        chk("haz read4 c1", bus2.o_raw_hazard, 0);
        tick();
        drv2(1'b1, 1'b0, 4'd9, 8'h00);
        #1;
        chk("haz read9 last stage", bus2.o_raw_hazard, 1);
        tick();
        drv2(1'b0, 1'b0, 4'd0, 8'h00);
        tick();
        tick();

        // Bubbles: write, idle, write, idle.
        exp_en_b   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_pend_b = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
        for (int c = 0; c < 7; c++) begin
            if (c == 0 || c == 2) drv2(1'b1, 1'b1, 4'(c + 1), 8'(c + 1));
            else drv2(1'b0, 1'b0, 4'd0, 8'h00);
            #1;
            chk($sformatf("bubble c%0d en_wr", c), bus2.o_en_wr, exp_en_b[c]);
            chk($sformatf("bubble c%0d pending", c), bus2.o_wr_pending, exp_pend_b[c]);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
